cache_tag_ctrl: RTL and testbench

CACHE_TAG_CTRL -- requirements
Module: cache_tag_ctrl

---
 rtl/cache_pkg.sv | 15 +
 rtl/cache_tag_ctrl_if.sv | 35 +++
 rtl/tag_cmp.sv | 27 ++
 rtl/cache_tag_ctrl.sv | 138 +++++++++++++
 tb/tb_cache_tag_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants, way index type and FSM encoding for the tag controller
package cache_pkg;

  localparam int WAYS = 4;

  typedef logic [1:0] way_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MISS_REQ  = 2'd1,
    ST_MISS_WAIT = 2'd2,
    ST_FILL      = 2'd3
  } state_t;

endpackage

// File: rtl/cache_tag_ctrl_if.sv
// rtl/cache_tag_ctrl_if.sv - lookup, response, LRU and memory-fetch signals of the tag controller
interface cache_tag_ctrl_if
  import cache_pkg::*;
#(
  parameter int TAG_W = 8
);

  logic             req_valid;
  logic [TAG_W-1:0] req_tag;
  logic             req_ready;
  logic             resp_valid;
  logic             resp_hit;
  way_idx_t         resp_way;
  way_idx_t         lru_way;
  way_idx_t         line_index;
  logic             hit;
  logic             lru_update;
  logic             mem_req_valid;
  logic [TAG_W-1:0] mem_req_tag;
  logic             mem_req_ready;
  logic             mem_resp_valid;

  modport master (
    output req_valid, req_tag, lru_way, mem_req_ready, mem_resp_valid,
    input  req_ready, resp_valid, resp_hit, resp_way, line_index, hit, lru_update,
           mem_req_valid, mem_req_tag
  );

  modport slave (
    input  req_valid, req_tag, lru_way, mem_req_ready, mem_resp_valid,
    output req_ready, resp_valid, resp_hit, resp_way, line_index, hit, lru_update,
           mem_req_valid, mem_req_tag
  );

endinterface

// File: rtl/tag_cmp.sv
// rtl/tag_cmp.sv - parallel tag compare with lowest-way priority on multiple matches
module tag_cmp
  import cache_pkg::*;
#(
  parameter int TAG_W = 8,
  parameter int WAYS  = cache_pkg::WAYS
) (
  input  logic [WAYS-1:0][TAG_W-1:0] tags,
  input  logic [WAYS-1:0]            valids,
  input  logic [TAG_W-1:0]           req_tag,
  output logic                       any_hit,
  output way_idx_t                   hit_way
);

  // Scanning downward lets the lowest matching way overwrite any higher one.
  always_comb begin
    any_hit = 1'b0;
    hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (valids[i] && (tags[i] == req_tag)) begin
        any_hit = 1'b1;
        hit_way = way_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/cache_tag_ctrl.sv
// rtl/cache_tag_ctrl.sv - 4-way tag store with hit lookup, miss fetch and fill FSM
// Optional CACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module cache_tag_ctrl
  import cache_pkg::*;
#(
  parameter int TAG_W = 8,
  parameter int WAYS  = cache_pkg::WAYS
) (
  input  logic             clk,
  input  logic             reset,
  cache_tag_ctrl_if.slave  bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count
`endif
);

  state_t                     state, state_nxt;
  logic [WAYS-1:0]            valid_q;
  logic [WAYS-1:0][TAG_W-1:0] tag_q;
  logic [TAG_W-1:0]           miss_tag_q;
  way_idx_t                   victim_q;
  way_idx_t                   hit_way_q;
  logic                       hit_pulse_q;
  logic                       cmp_hit;
  way_idx_t                   cmp_way;
  logic                       accept;
  logic                       inv_found;
  way_idx_t                   inv_way;

  tag_cmp #(
    .TAG_W (TAG_W),
    .WAYS  (WAYS)
  ) u_tag_cmp (
    .tags    (tag_q),
    .valids  (valid_q),
    .req_tag (bus.req_tag),
    .any_hit (cmp_hit),
    .hit_way (cmp_way)
  );

  assign accept = bus.req_valid && (state == ST_IDLE);

  // Empty ways are always filled before the LRU choice is consulted.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        inv_found = 1'b1;
        inv_way   = way_idx_t'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (accept && !cmp_hit)   state_nxt = ST_MISS_REQ;
      ST_MISS_REQ:  if (bus.mem_req_ready)    state_nxt = ST_MISS_WAIT;
      ST_MISS_WAIT: if (bus.mem_resp_valid)   state_nxt = ST_FILL;
      ST_FILL:                                state_nxt = ST_IDLE;
      default:                                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready     = (state == ST_IDLE);
    bus.mem_req_valid = (state == ST_MISS_REQ);
    bus.mem_req_tag   = (state == ST_MISS_REQ) ? miss_tag_q : '0;
    bus.resp_valid    = 1'b0;
    bus.resp_hit      = 1'b0;
    bus.resp_way      = '0;
    bus.lru_update    = 1'b0;
    bus.hit           = 1'b0;
    bus.line_index    = '0;
    // FILL and a registered hit pulse never coincide: hits are only accepted in IDLE.
    if (state == ST_FILL) begin
      bus.resp_valid = 1'b1;
      bus.resp_way   = victim_q;
      bus.lru_update = 1'b1;
      bus.hit        = 1'b1;
      bus.line_index = victim_q;
    end else if (hit_pulse_q) begin
      bus.resp_valid = 1'b1;
      bus.resp_hit   = 1'b1;
      bus.resp_way   = hit_way_q;
      bus.lru_update = 1'b1;
      bus.hit        = 1'b1;
      bus.line_index = hit_way_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      valid_q     <= '0;
      tag_q       <= '0;
      miss_tag_q  <= '0;
      victim_q    <= '0;
      hit_way_q   <= '0;
      hit_pulse_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      hit_pulse_q <= accept && cmp_hit;
      if (accept && cmp_hit) begin
        hit_way_q <= cmp_way;
      end
      if (accept && !cmp_hit) begin
        miss_tag_q <= bus.req_tag;
      end
      if ((state == ST_MISS_WAIT) && bus.mem_resp_valid) begin
        victim_q <= inv_found ? inv_way : bus.lru_way;
      end
      if (state == ST_FILL) begin
        tag_q[victim_q]   <= miss_tag_q;
        valid_q[victim_q] <= 1'b1;
      end
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (bus.resp_valid) begin
      if (bus.resp_hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// tb/tb_cache_tag_ctrl.sv - scoreboard bench for cache_tag_ctrl with directed lookup/miss/reset vectors
module tb_cache_tag_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  typedef struct packed {
    logic       hit;
    logic [1:0] way;
  } exp_t;

  exp_t exp_q[$];

  cache_tag_ctrl_if #(.TAG_W(8)) bus ();

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  cache_tag_ctrl #(
    .TAG_W (8),
    .WAYS  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_resp: got resp_way=%0d resp_hit=%0d expected no response",
                 bus.resp_way, bus.resp_hit);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_hit", bus.resp_hit, e.hit);
        chk("resp_way", bus.resp_way, e.way);
        chk("line_index", bus.line_index, e.way);
        chk("hit_sel", bus.hit, 1);
        chk("lru_update", bus.lru_update, 1);
      end
    end
  end

  task automatic do_reset();
    bus.req_valid      = 1'b0;
    bus.req_tag        = '0;
    bus.lru_way        = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Called and returns just after a rising edge, so hits can be issued back to back.
  task automatic do_hit(input logic [7:0] tag, input logic [1:0] way);
    exp_q.push_back('{hit: 1'b1, way: way});
    chk("hit_req_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_tag   = tag;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("hit_next_cycle", bus.resp_valid, 1);
  endtask

  task automatic do_miss(input logic [7:0] tag, input logic [1:0] lru,
                         input logic [1:0] exp_way, input int stall);
    exp_q.push_back('{hit: 1'b0, way: exp_way});
    chk("miss_req_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_tag   = tag;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_tag   = 8'hEE;
    chk("miss_no_early_resp", bus.resp_valid, 0);
    for (int i = 0; i < stall; i++) begin
      chk("stall_mem_req_valid", bus.mem_req_valid, 1);
      chk("stall_mem_req_tag", bus.mem_req_tag, tag);
      chk("stall_req_ready", bus.req_ready, 0);
      bus.mem_resp_valid = (i == 1);
      @(posedge clk);
      #1;
    end
    bus.mem_resp_valid = 1'b0;
    chk("mem_req_valid", bus.mem_req_valid, 1);
    chk("mem_req_tag", bus.mem_req_tag, tag);
    bus.mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b0;
    chk("wait_mem_req_valid", bus.mem_req_valid, 0);
    chk("wait_req_ready", bus.req_ready, 0);
    bus.lru_way        = lru;
    bus.mem_resp_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_resp_valid = 1'b0;
    bus.lru_way        = ~lru;
    chk("fill_strobe", bus.resp_valid, 1);
    @(posedge clk);
    #1;
    chk("back_to_idle", bus.req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    do_reset();

    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("rst_lru_update", bus.lru_update, 0);
    chk("rst_hit", bus.hit, 0);
    chk("rst_line_index", bus.line_index, 0);

    // Empty cache: first miss lands in way 0 regardless of LRU.
    do_miss(8'h12, 2'd3, 2'd0, 0);

    do_reset();
    do_miss(8'h10, 2'd3, 2'd0, 0);
    do_miss(8'h11, 2'd0, 2'd1, 0);
    do_miss(8'h12, 2'd0, 2'd2, 0);
    do_miss(8'h13, 2'd1, 2'd3, 0);
    do_hit(8'h11, 2'd1);
    chk("hit_line_index", bus.line_index, 1);
    chk("hit_select", bus.hit, 1);
    do_hit(8'h13, 2'd3);
    do_hit(8'h10, 2'd0);
    @(posedge clk);
    #1;
    chk("idle_lru_update", bus.lru_update, 0);
    chk("idle_line_index", bus.line_index, 0);

    // Full cache: victim comes from lru_way.
    do_miss(8'h55, 2'd2, 2'd2, 0);
    do_hit(8'h55, 2'd2);
    do_miss(8'h12, 2'd1, 2'd1, 0);
    do_hit(8'h12, 2'd1);
    do_hit(8'h55, 2'd2);

    // Long memory stall with a stray mem_resp_valid during MISS_REQ.
    do_miss(8'h77, 2'd0, 2'd0, 5);
    do_hit(8'h77, 2'd0);

    // Reset in MISS_WAIT abandons the fetch.
    bus.req_valid = 1'b1;
    bus.req_tag   = 8'h99;
    @(posedge clk);
    #1;
    bus.req_valid     = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b0;
    chk("rw_in_wait", bus.mem_req_valid, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("rw_async_ready", bus.req_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.mem_resp_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_resp_valid = 1'b0;
    chk("rw_no_resp", bus.resp_valid, 0);
    chk("rw_req_ready", bus.req_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    do_miss(8'h55, 2'd3, 2'd0, 0);
    do_miss(8'h77, 2'd3, 2'd1, 0);

`ifdef CACHE_STATS_EN
    do_reset();
    chk("stats_rst_hit", hit_count, 0);
    chk("stats_rst_miss", miss_count, 0);
    do_miss(8'hA0, 2'd0, 2'd0, 0);
    do_miss(8'hA1, 2'd0, 2'd1, 0);
    do_hit(8'hA0, 2'd0);
    do_hit(8'hA1, 2'd1);
    do_hit(8'hA0, 2'd0);
    @(posedge clk);
    #1;
    chk("stats_hit_count", hit_count, 3);
    chk("stats_miss_count", miss_count, 2);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
